rename_ckpt_ctrl: RTL and testbench

Branch checkpoint controller that sequences the physical-register free list during speculation. It sits beside the rename stage and gives each renamed branch a checkpoint slot holding the free-list head pointer. On branch resolution it retires the slot in order. On a mispredict it drives the free list's restore port and squashes younger checkpoints, stalling rename for the recovery cycle.

---
 rtl/rename_ckpt_ctrl_if.sv | 29 ++
 rtl/rename_ckpt_ctrl.sv | 103 ++++++++++
 tb/tb_rename_ckpt_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rename_ckpt_ctrl_if.sv
// Rename/execute/free-list side bus of the branch checkpoint controller.
interface rename_ckpt_ctrl_if #(
  parameter int unsigned NUM_CKPT  = 4,
  parameter int unsigned TAG_BITS  = 2,
  parameter int unsigned PREG_BITS = 7
);
  logic                 br_valid;
  logic [PREG_BITS-1:0] br_head_ptr;
  logic                 br_ready;
  logic [TAG_BITS-1:0]  br_tag;
  logic                 resolve_valid;
  logic [TAG_BITS-1:0]  resolve_tag;
  logic                 resolve_mispredict;
  logic                 fl_restore_en;
  logic [PREG_BITS-1:0] fl_restore_ptr;
  logic [NUM_CKPT-1:0]  kill_mask;
  logic                 stall_rename;
  logic [TAG_BITS:0]    ckpt_count;

  modport master (
    output br_valid, br_head_ptr, resolve_valid, resolve_tag, resolve_mispredict,
    input  br_ready, br_tag, fl_restore_en, fl_restore_ptr, kill_mask, stall_rename, ckpt_count
  );

  modport slave (
    input  br_valid, br_head_ptr, resolve_valid, resolve_tag, resolve_mispredict,
    output br_ready, br_tag, fl_restore_en, fl_restore_ptr, kill_mask, stall_rename, ckpt_count
  );
endinterface

// File: rtl/rename_ckpt_ctrl.sv
// Branch checkpoint controller: allocates free-list head checkpoints per branch,
// retires them in order and drives free-list restore on a mispredict.
module rename_ckpt_ctrl #(
  parameter int unsigned NUM_CKPT  = 4,
  parameter int unsigned TAG_BITS  = 2,
  parameter int unsigned PREG_BITS = 7
) (
  input logic               clk,
  input logic               rst,
  rename_ckpt_ctrl_if.slave io_bus
);
  localparam int unsigned PTR_W = TAG_BITS + 1;

  typedef enum logic {S_IDLE, S_RECOVER} state_t;

  state_t               r_state, w_state_nxt;
  logic [PTR_W-1:0]     r_alloc_ptr, r_retire_ptr, w_alloc_ptr_nxt, w_count;
  logic [PREG_BITS-1:0] r_ptr_mem [NUM_CKPT];
  logic [NUM_CKPT-1:0]  r_valid, r_resolved, w_valid_nxt, w_resolved_nxt, w_younger;
  logic                 r_restore_en;
  logic [PREG_BITS-1:0] r_restore_ptr;
  logic [NUM_CKPT-1:0]  r_kill_mask;
  logic                 w_full, w_br_ready, w_res_hit, w_mispredict, w_alloc, w_retire;
  logic [TAG_BITS-1:0]  w_alloc_idx, w_tail, w_t_age;

  assign w_count      = r_alloc_ptr - r_retire_ptr;
  assign w_full       = (w_count == PTR_W'(NUM_CKPT));
  assign w_br_ready   = (r_state == S_IDLE) && !w_full;
  assign w_alloc_idx  = r_alloc_ptr[TAG_BITS-1:0];
  assign w_tail       = r_retire_ptr[TAG_BITS-1:0];
  assign w_res_hit    = io_bus.resolve_valid && r_valid[io_bus.resolve_tag];
  assign w_mispredict = w_res_hit && io_bus.resolve_mispredict;
  assign w_alloc      = io_bus.br_valid && w_br_ready && !w_mispredict;
  assign w_retire     = r_valid[w_tail] && r_resolved[w_tail];
  assign w_t_age      = io_bus.resolve_tag - w_tail;

  // Younger = live slot whose distance from the retire tail exceeds that of the mispredicted tag.
  always_comb begin
    logic [TAG_BITS-1:0] v_age;
    w_younger = '0;
    v_age     = '0;
    for (int unsigned i = 0; i < NUM_CKPT; i++) begin
      v_age        = TAG_BITS'(i) - w_tail;
      w_younger[i] = r_valid[i] && (v_age > w_t_age);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_valid_nxt     = r_valid;
    w_resolved_nxt  = r_resolved;
    w_alloc_ptr_nxt = r_alloc_ptr;
    case (r_state)
      S_IDLE:    if (w_mispredict)  w_state_nxt = S_RECOVER;
      S_RECOVER: if (!w_mispredict) w_state_nxt = S_IDLE;
    endcase
    if (w_retire)  w_valid_nxt[w_tail] = 1'b0;
    if (w_res_hit) w_resolved_nxt[io_bus.resolve_tag] = 1'b1;
    // A same-cycle allocation is younger than the mispredict and is dropped.
    if (w_mispredict) begin
      w_valid_nxt     = w_valid_nxt & ~w_younger;
      w_alloc_ptr_nxt = r_retire_ptr + PTR_W'(w_t_age) + PTR_W'(1);
    end else if (w_alloc) begin
      w_valid_nxt[w_alloc_idx]    = 1'b1;
      w_resolved_nxt[w_alloc_idx] = 1'b0;
      w_alloc_ptr_nxt             = r_alloc_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_alloc_ptr   <= '0;
      r_retire_ptr  <= '0;
      r_valid       <= '0;
      r_resolved    <= '0;
      r_restore_en  <= 1'b0;
      r_restore_ptr <= '0;
      r_kill_mask   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_alloc_ptr   <= w_alloc_ptr_nxt;
      r_retire_ptr  <= r_retire_ptr + PTR_W'(w_retire);
      r_valid       <= w_valid_nxt;
      r_resolved    <= w_resolved_nxt;
      r_restore_en  <= w_mispredict;
      r_kill_mask   <= w_mispredict ? w_younger : '0;
      if (w_mispredict) r_restore_ptr <= r_ptr_mem[io_bus.resolve_tag];
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) r_ptr_mem[w_alloc_idx] <= io_bus.br_head_ptr;
  end

  assign io_bus.br_ready       = w_br_ready;
  assign io_bus.br_tag         = w_alloc_idx;
  assign io_bus.fl_restore_en  = r_restore_en;
  assign io_bus.fl_restore_ptr = r_restore_ptr;
  assign io_bus.kill_mask      = r_kill_mask;
  assign io_bus.stall_rename   = (r_state == S_RECOVER);
  assign io_bus.ckpt_count     = w_count;
endmodule

// File: tb/tb_rename_ckpt_ctrl.sv
// Bench for rename_ckpt_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_rename_ckpt_ctrl;
  localparam int N = 4;
  localparam int TB = 2;
  localparam int PB = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rename_ckpt_ctrl_if #(.NUM_CKPT(N), .TAG_BITS(TB), .PREG_BITS(PB)) bus ();
  rename_ckpt_ctrl #(.NUM_CKPT(N), .TAG_BITS(TB), .PREG_BITS(PB)) dut (
    .clk(clk), .rst(rst), .io_bus(bus)
  );

  // Model: live checkpoints oldest-first, each with its tag, pointer and resolved flag.
  typedef struct {int tag; int ptr; bit res;} ck_t;
  ck_t live[$];
  int  m_next, m_rptr, m_kill;
  bit  m_rec;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic model_step();
    bit retire, mp, rdy;
    int k;
    ck_t e;
    if (rst) begin
      live.delete(); m_next = 0; m_rec = 0; m_rptr = 0; m_kill = 0;
      return;
    end
    rdy = !m_rec && live.size() < N;
    retire = live.size() > 0 && live[0].res;
    mp = 0; k = -1;
    foreach (live[i]) if (live[i].tag == int'(bus.resolve_tag)) k = i;
    if (bus.resolve_valid && k >= 0) begin
      e = live[k]; e.res = 1; live[k] = e;
      if (bus.resolve_mispredict) begin
        mp = 1; m_rptr = e.ptr; m_kill = 0;
        for (int j = k + 1; j < live.size(); j++) m_kill |= (1 << live[j].tag);
        while (live.size() > k + 1) void'(live.pop_back());
        m_next = (e.tag + 1) % N;
      end
    end
    if (!mp && bus.br_valid && rdy) begin
      e.tag = m_next; e.ptr = int'(bus.br_head_ptr); e.res = 0;
      live.push_back(e);
      m_next = (m_next + 1) % N;
    end
    if (retire) void'(live.pop_front());
    m_rec = mp;
    if (!mp) m_kill = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.br_valid = 0; bus.br_head_ptr = '0;
    bus.resolve_valid = 0; bus.resolve_tag = '0; bus.resolve_mispredict = 0;
  endtask

  task automatic do_reset();
    idle_in(); rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic resolve(input int tag, input bit mis);
    bus.resolve_valid = 1; bus.resolve_tag = TB'(tag); bus.resolve_mispredict = mis;
    tick();
    idle_in();
  endtask

  task automatic fill4(input int base);
    for (int i = 0; i < 4; i++) begin
      bus.br_valid = 1; bus.br_head_ptr = PB'(base + i); tick();
    end
    idle_in();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.br_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0d want 1", bus.br_ready); end
    n_vec++; if (bus.br_tag !== 2'd0) begin n_err++; $display("FAIL reset_tag: got %0d want 0", bus.br_tag); end
    n_vec++; if ({bus.fl_restore_en, bus.fl_restore_ptr, bus.kill_mask, bus.stall_rename} !== '0) begin
      n_err++; $display("FAIL reset_restore: en=%0d ptr=%0d kill=%b stall=%0d want all 0",
                        bus.fl_restore_en, bus.fl_restore_ptr, bus.kill_mask, bus.stall_rename); end
    n_vec++; if (bus.ckpt_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.ckpt_count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      bus.br_valid = 1; bus.br_head_ptr = PB'(40 + i);
      n_vec++; if (bus.br_tag !== TB'(i) || bus.br_ready !== 1'b1) begin
        n_err++; $display("FAIL fill_tag%0d: got tag=%0d ready=%0d want tag=%0d ready=1", i, bus.br_tag, bus.br_ready, i); end
      tick();
    end
    idle_in();
    n_vec++; if (bus.ckpt_count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d want 4", bus.ckpt_count); end
    n_vec++; if (bus.br_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready: got %0d want 0", bus.br_ready); end
    bus.br_valid = 1; bus.br_head_ptr = PB'(99); tick(); idle_in();
    n_vec++; if (bus.ckpt_count !== 3'd4 || bus.br_tag !== 2'd0) begin
      n_err++; $display("FAIL fill_fifth: got count=%0d tag=%0d want count=4 tag=0", bus.ckpt_count, bus.br_tag); end
  endtask

  task automatic test_ooo_resolve();
    resolve(2, 0);
    resolve(0, 0);
    n_vec++; if (bus.ckpt_count !== 3'd4) begin n_err++; $display("FAIL ooo_noretire: got %0d want 4", bus.ckpt_count); end
    resolve(1, 0);
    n_vec++; if (bus.ckpt_count !== 3'd3) begin n_err++; $display("FAIL ooo_retire0: got %0d want 3", bus.ckpt_count); end
    tick();
    n_vec++; if (bus.ckpt_count !== 3'd2) begin n_err++; $display("FAIL ooo_retire1: got %0d want 2", bus.ckpt_count); end
    tick();
    n_vec++; if (bus.ckpt_count !== 3'd1) begin n_err++; $display("FAIL ooo_retire2: got %0d want 1", bus.ckpt_count); end
    tick();
    n_vec++; if (bus.ckpt_count !== 3'd1) begin n_err++; $display("FAIL ooo_final: got %0d want 1", bus.ckpt_count); end
  endtask

  task automatic test_mispredict();
    do_reset();
    fill4(40);
    resolve(1, 1);
    n_vec++; if (bus.fl_restore_en !== 1'b1 || bus.stall_rename !== 1'b1 || bus.br_ready !== 1'b0) begin
      n_err++; $display("FAIL mp_recover: got en=%0d stall=%0d ready=%0d want 1 1 0", bus.fl_restore_en, bus.stall_rename, bus.br_ready); end
    n_vec++; if (bus.fl_restore_ptr !== 7'd41) begin n_err++; $display("FAIL mp_ptr: got %0d want 41", bus.fl_restore_ptr); end
    n_vec++; if (bus.kill_mask !== 4'b1100) begin n_err++; $display("FAIL mp_kill: got %b want 1100", bus.kill_mask); end
    n_vec++; if (bus.ckpt_count !== 3'd2) begin n_err++; $display("FAIL mp_count: got %0d want 2", bus.ckpt_count); end
    tick();
    n_vec++; if ({bus.fl_restore_en, bus.stall_rename, bus.kill_mask} !== 6'b0 || bus.br_ready !== 1'b1) begin
      n_err++; $display("FAIL mp_release: got en=%0d stall=%0d kill=%b ready=%0d want 0 0 0000 1",
                        bus.fl_restore_en, bus.stall_rename, bus.kill_mask, bus.br_ready); end
    n_vec++; if (bus.br_tag !== 2'd2) begin n_err++; $display("FAIL mp_next_tag: got %0d want 2", bus.br_tag); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.br_valid = 1; bus.br_head_ptr = PB'(10 + i); tick(); idle_in();
      resolve(i % N, 0);
      tick();
    end
    n_vec++; if (bus.ckpt_count !== 3'd0 || bus.br_tag !== 2'd2) begin
      n_err++; $display("FAIL wrap_drain: got count=%0d tag=%0d want 0 2", bus.ckpt_count, bus.br_tag); end
    fill4(50);
    n_vec++; if (bus.ckpt_count !== 3'd4) begin n_err++; $display("FAIL wrap_full: got %0d want 4", bus.ckpt_count); end
    resolve(0, 1);
    n_vec++; if (bus.kill_mask !== 4'b0010 || bus.fl_restore_ptr !== 7'd52) begin
      n_err++; $display("FAIL wrap_mp: got kill=%b ptr=%0d want 0010 52", bus.kill_mask, bus.fl_restore_ptr); end
    n_vec++; if (bus.ckpt_count !== 3'd3) begin n_err++; $display("FAIL wrap_count: got %0d want 3", bus.ckpt_count); end
    tick();
    n_vec++; if (bus.br_tag !== 2'd1 || bus.ckpt_count !== 3'd3) begin
      n_err++; $display("FAIL wrap_after: got tag=%0d count=%0d want 1 3", bus.br_tag, bus.ckpt_count); end
  endtask

  task automatic test_mp_with_alloc();
    bus.br_valid = 1; bus.br_head_ptr = PB'(77);
    resolve(3, 1);
    n_vec++; if (bus.kill_mask !== 4'b0001 || bus.fl_restore_ptr !== 7'd51 || bus.ckpt_count !== 3'd2) begin
      n_err++; $display("FAIL mpa_drop: got kill=%b ptr=%0d count=%0d want 0001 51 2", bus.kill_mask, bus.fl_restore_ptr, bus.ckpt_count); end
    tick();
    n_vec++; if (bus.br_tag !== 2'd0) begin n_err++; $display("FAIL mpa_tag: got %0d want 0", bus.br_tag); end
    resolve(0, 1);
    n_vec++; if (bus.fl_restore_en !== 1'b0 || bus.stall_rename !== 1'b0) begin
      n_err++; $display("FAIL mpa_squashed_ignored: got en=%0d stall=%0d want 0 0", bus.fl_restore_en, bus.stall_rename); end
    resolve(2, 0);
    tick(); tick();
    n_vec++; if (bus.ckpt_count !== 3'd0) begin n_err++; $display("FAIL mpa_drain: got %0d want 0", bus.ckpt_count); end
  endtask

  task automatic test_remispredict_reset();
    do_reset();
    fill4(40);
    resolve(2, 1);
    n_vec++; if (bus.fl_restore_ptr !== 7'd42 || bus.kill_mask !== 4'b1000) begin
      n_err++; $display("FAIL remp_first: got ptr=%0d kill=%b want 42 1000", bus.fl_restore_ptr, bus.kill_mask); end
    resolve(0, 1);
    n_vec++; if (bus.fl_restore_en !== 1'b1 || bus.stall_rename !== 1'b1 || bus.fl_restore_ptr !== 7'd40) begin
      n_err++; $display("FAIL remp_extend: got en=%0d stall=%0d ptr=%0d want 1 1 40", bus.fl_restore_en, bus.stall_rename, bus.fl_restore_ptr); end
    n_vec++; if (bus.kill_mask !== 4'b0110 || bus.ckpt_count !== 3'd1) begin
      n_err++; $display("FAIL remp_kill: got kill=%b count=%0d want 0110 1", bus.kill_mask, bus.ckpt_count); end
    rst = 1; tick(); rst = 0;
    n_vec++; if ({bus.fl_restore_en, bus.fl_restore_ptr, bus.kill_mask, bus.stall_rename} !== '0
                 || bus.br_ready !== 1'b1 || bus.br_tag !== 2'd0 || bus.ckpt_count !== 3'd0) begin
      n_err++; $display("FAIL remp_reset: got en=%0d ptr=%0d kill=%b stall=%0d ready=%0d tag=%0d count=%0d",
                        bus.fl_restore_en, bus.fl_restore_ptr, bus.kill_mask, bus.stall_rename,
                        bus.br_ready, bus.br_tag, bus.ckpt_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(149) == 0);
      bus.br_valid = $urandom_range(1);
      bus.br_head_ptr = PB'($urandom);
      bus.resolve_valid = ($urandom_range(9) < 4);
      bus.resolve_tag = TB'($urandom);
      bus.resolve_mispredict = ($urandom_range(4) == 0);
      n_vec++;
      if (bus.br_ready !== (!m_rec && live.size() < N) || bus.br_tag !== TB'(m_next)
          || bus.ckpt_count !== 3'(live.size()) || bus.fl_restore_en !== m_rec
          || bus.stall_rename !== m_rec || bus.kill_mask !== 4'(m_kill)
          || bus.fl_restore_ptr !== PB'(m_rptr)) begin
        n_err++;
        $display("FAIL rand_cycle%0d: got ready=%0d tag=%0d count=%0d en=%0d stall=%0d kill=%b ptr=%0d want %0d %0d %0d %0d %0d %b %0d",
                 c, bus.br_ready, bus.br_tag, bus.ckpt_count, bus.fl_restore_en, bus.stall_rename,
                 bus.kill_mask, bus.fl_restore_ptr, (!m_rec && live.size() < N), m_next, live.size(),
                 m_rec, m_rec, 4'(m_kill), m_rptr);
      end
      tick();
    end
    rst = 0; idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_fill();
    test_ooo_resolve();
    test_mispredict();
    test_wrap();
    test_mp_with_alloc();
    test_remispredict_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
